// File: rtl/bram_load_scheduler_if.sv
// Bundle of loader-client request/grant signals, BRAM read port and tagged read-return stream.
interface bram_load_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned LEN_WIDTH  = 15
) ();
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic                          busy;
  logic                          bram_en;
  logic                          bram_ren;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [W-1:0]                  bram_dout;
  logic                          rd_valid;
  logic [W-1:0]                  rd_data;
  logic [LEN_WIDTH-1:0]          rd_idx;

  // scheduler side
  modport master (
    input  req, req_base, req_len, bram_dout,
    output grant, done, busy, bram_en, bram_ren, bram_addr, rd_valid, rd_data, rd_idx
  );

  // clients plus BRAM side
  modport slave (
    output req, req_base, req_len, bram_dout,
    input  grant, done, busy, bram_en, bram_ren, bram_addr, rd_valid, rd_data, rd_idx
  );
endinterface

// File: rtl/bram_load_scheduler.sv
// Round-robin scheduler sharing one read-only parameter BRAM between loader clients;
// issues the granted burst and returns each word tagged with its index in the burst.
module bram_load_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned LEN_WIDTH  = 15,
  parameter int unsigned READ_LAT   = 2
) (
  input logic                   clk,
  input logic                   rst,
  bram_load_scheduler_if.master bus
);
  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [READ_LAT-1:0]   vpipe_q, vpipe_d;
  logic [OWN_W-1:0]      owner_q, owner_d;
  logic [OWN_W-1:0]      last_q, last_d;

  logic [OWN_W-1:0]      cand;
  logic [OWN_W-1:0]      pick;
  logic [ADDR_WIDTH-1:0] pick_base;
  logic [LEN_WIDTH-1:0]  pick_len;
  logic                  pend;

  // Scan from farthest to nearest after last owner so the nearest requester wins.
  always_comb begin
    pick = last_q;
    cand = last_q;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = OWN_W'((32'(last_q) + 32'(k)) % NUM_REQ);
      if (bus.req[cand]) pick = cand;
    end
  end

  always_comb begin
    pick_base = '0;
    pick_len  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick == OWN_W'(i)) begin
        pick_base = bus.req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Reads still in flight behind the stage currently presenting rd_valid.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < int'(READ_LAT) - 1; i++) pend = pend | vpipe_q[i];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    en_d     = en_q;
    ren_d    = ren_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    idx_d    = idx_q + LEN_WIDTH'(vpipe_q[READ_LAT-1]);
    vpipe_d  = vpipe_q;
    vpipe_d[0] = ren_q;
    for (int i = 1; i < int'(READ_LAT); i++) vpipe_d[i] = vpipe_q[i-1];

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          grant_d = NUM_REQ'(1) << pick;
          owner_d = pick;
          addr_d  = pick_base;
          len_d   = pick_len;
          idx_d   = '0;
          if (pick_len == '0) begin
            state_d = S_DONE;
            done_d  = NUM_REQ'(1) << pick;
          end else begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            ren_d   = 1'b1;
            cnt_d   = LEN_WIDTH'(1);
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == len_q) begin
          ren_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (!pend) begin
          en_d    = 1'b0;
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        grant_d = '0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vpipe_q <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vpipe_q <= vpipe_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.bram_en   = en_q;
  assign bus.bram_ren  = ren_q;
  assign bus.bram_addr = addr_q;
  assign bus.rd_valid  = vpipe_q[READ_LAT-1];
  assign bus.rd_idx    = idx_q;
  assign bus.rd_data   = W'(bus.bram_dout);
endmodule

// File: tb/tb_bram_load_scheduler.sv
// Scoreboard bench for bram_load_scheduler: a round-robin/burst reference model pushes expected
// grants, addresses, returned words and done pulses; a negedge monitor pops and compares them.
module tb_bram_load_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned AW      = 15;
  localparam int unsigned LW      = 15;
  localparam int unsigned LAT     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_load_scheduler_if #(.NUM_REQ(NUM_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  bram_load_scheduler #(
    .NUM_REQ(NUM_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // BRAM with two-cycle read latency
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] s1;
  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_ren) s1 <= mem[bus.bram_addr];
    bus.bram_dout <= s1;
  end

  typedef struct {int owner; int len;} grant_t;
  typedef struct {logic [W-1:0] data; int idx; int owner;} rd_t;

  grant_t exp_grant_q[$];
  int     exp_addr_q[$];
  rd_t    exp_rd_q[$];
  int     exp_done_q[$];
  int     ren_cyc_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int cur_len = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  logic [NUM_REQ-1:0] req_v = '0;
  int base_v[NUM_REQ];
  int len_v[NUM_REQ];
  int last_owner = NUM_REQ - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    bus.req = req_v;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_base[i*AW +: AW] = AW'(base_v[i]);
      bus.req_len[i*LW +: LW]  = LW'(len_v[i]);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] m);
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int c;
      c = (last_owner + k) % int'(NUM_REQ);
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Expected outcome of the next grant, computed from the request set as the DUT will sample it.
  task automatic predict(output int o);
    grant_t g;
    rd_t r;
    o = rr_pick(req_v);
    g.owner = o;
    g.len   = len_v[o];
    exp_grant_q.push_back(g);
    for (int i = 0; i < len_v[o]; i++) begin
      int a;
      a = (base_v[o] + i) % (1 << AW);
      exp_addr_q.push_back(a);
      r.data  = mem[a];
      r.idx   = i;
      r.owner = o;
      exp_rd_q.push_back(r);
    end
    exp_done_q.push_back(o);
    last_owner = o;
  endtask

  // Starts in an IDLE cycle at posedge+1 and returns in the following IDLE cycle.
  task automatic do_burst(input bit tweak, input bit drop_owner);
    int o;
    int ren_seen;
    bit got;
    bit tweaked;
    ren_seen = 0;
    got = 1'b0;
    tweaked = 1'b0;
    chk("idle_busy", bus.busy, 0);
    apply();
    predict(o);
    @(posedge clk); #1;
    chk("grant_busy", bus.busy, 1);
    for (int t = 0; t < 400 && !got; t++) begin
      if (bus.done !== '0) got = 1'b1;
      else begin
        if (bus.bram_ren === 1'b1) ren_seen++;
        if (tweak && !tweaked && ren_seen == 2) begin
          req_v[o]  = 1'b0;
          base_v[o] = int'($urandom_range(0, (1 << AW) - 1));
          len_v[o]  = int'($urandom_range(1, 9));
          apply();
          tweaked = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    chk("done_seen", got, 1);
    if (drop_owner) req_v[o] = 1'b0;
    apply();
    @(posedge clk); #1;
  endtask

  task automatic new_client(input int i);
    len_v[i]  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 9));
    base_v[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range((1 << AW) - 8, (1 << AW) - 1))
                                            : int'($urandom_range(0, (1 << AW) - 1));
  endtask

  task automatic rand_round();
    logic [NUM_REQ-1:0] nb;
    nb = NUM_REQ'($urandom);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (nb[i] && !req_v[i]) begin
        new_client(i);
        req_v[i] = 1'b1;
      end
    end
    if (req_v == '0) begin
      int i;
      i = int'($urandom_range(0, NUM_REQ - 1));
      new_client(i);
      req_v[i] = 1'b1;
    end
    do_burst($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_en"}, bus.bram_en, 0);
    chk({tag, "_ren"}, bus.bram_ren, 0);
    chk({tag, "_addr"}, bus.bram_addr, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_idx"}, bus.rd_idx, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, read, return or done.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_grant = '0;
      ren_cyc_q.delete();
    end else begin
      if (bus.grant !== '0 && prev_grant === '0) begin
        chk("grant_expected", exp_grant_q.size() > 0, 1);
        if (exp_grant_q.size() > 0) begin
          grant_t g;
          g = exp_grant_q.pop_front();
          chk("grant", bus.grant, 64'(1) << g.owner);
          grant_cyc = cyc;
          cur_len = g.len;
        end
      end
      if (bus.bram_ren === 1'b1) begin
        chk("ren_with_en", bus.bram_en, 1);
        chk("addr_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) chk("bram_addr", bus.bram_addr, exp_addr_q.pop_front());
        ren_cyc_q.push_back(cyc);
      end
      if (bus.rd_valid === 1'b1) begin
        chk("rd_after_ren", ren_cyc_q.size() > 0, 1);
        if (ren_cyc_q.size() > 0) chk("rd_latency", cyc - ren_cyc_q.pop_front(), LAT);
        chk("rd_expected", exp_rd_q.size() > 0, 1);
        if (exp_rd_q.size() > 0) begin
          rd_t r;
          r = exp_rd_q.pop_front();
          chk("rd_data", bus.rd_data, r.data);
          chk("rd_idx", bus.rd_idx, r.idx);
          chk("rd_owner", bus.grant, 64'(1) << r.owner);
        end
      end
      if (bus.done !== '0) begin
        chk("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) begin
          int o;
          o = exp_done_q.pop_front();
          chk("done", bus.done, 64'(1) << o);
          chk("burst_cycles", cyc - grant_cyc, (cur_len == 0) ? 0 : cur_len + int'(LAT));
        end
      end
      chk("busy_vs_grant", bus.busy, |bus.grant);
      prev_grant = bus.grant;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    int rens;
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'($urandom);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      base_v[i] = 0;
      len_v[i]  = 1;
    end
    rst = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // single burst
    req_v = 4'b0001; base_v[0] = 16384; len_v[0] = 8;
    do_burst(1'b0, 1'b1);

    // zero length
    req_v = 4'b0100; base_v[2] = 77; len_v[2] = 0;
    do_burst(1'b0, 1'b1);

    // address wrap
    req_v = 4'b1000; base_v[3] = 32766; len_v[3] = 4;
    do_burst(1'b0, 1'b1);

    // contention with requests held: expect owners 0,1,3,0
    req_v = 4'b1011;
    base_v[0] = 100; base_v[1] = 200; base_v[3] = 300;
    len_v[0] = 3; len_v[1] = 3; len_v[3] = 3;
    repeat (4) do_burst(1'b0, 1'b0);
    req_v = '0;

    // mid-burst request drop and base change, then no re-grant
    req_v = 4'b0010; base_v[1] = 500; len_v[1] = 6;
    do_burst(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("no_regrant_busy", bus.busy, 0);
      @(posedge clk); #1;
    end

    // reset after three reads of an eight-word burst
    req_v = 4'b0100; base_v[2] = 1000; len_v[2] = 8;
    apply();
    predict(o);
    @(posedge clk); #1;
    rens = 0;
    for (int t = 0; t < 20 && rens < 3; t++) begin
      if (bus.bram_ren === 1'b1) rens++;
      if (rens < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reads_seen", rens, 3);
    rst = 1'b1;
    req_v = '0;
    apply();
    exp_grant_q.delete(); exp_addr_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
    last_owner = NUM_REQ - 1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", bus.rd_valid, 0);
      chk("abort_no_done", bus.done, 0);
      @(posedge clk); #1;
    end

    // round-robin restarts at client 0
    req_v = 4'b1111;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      base_v[i] = 2000 + 10 * i;
      len_v[i]  = 2;
    end
    do_burst(1'b0, 1'b1);

    for (int n = 0; n < 40; n++) rand_round();

    req_v = '0;
    apply();
    repeat (6) @(posedge clk);
    #1;
    chk("left_grants", exp_grant_q.size(), 0);
    chk("left_addrs", exp_addr_q.size(), 0);
    chk("left_reads", exp_rd_q.size(), 0);
    chk("left_dones", exp_done_q.size(), 0);
    chk("left_inflight", ren_cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
